instr_fetch_responder: RTL and testbench

Responder side of the PC-to-instruction-memory interface: accepts byte addresses issued by the program counter and returns the addressed 32-bit instruction words in order, with a valid/ready handshake on both sides. It holds the instruction store (single-clock word array with a program-load write port), a one-deep registered read stage and a 3-entry output buffer so a stalled decode stage never drops a fetch. A flush input discards everything in flight for branch redirects.

---
 rtl/instr_fetch_responder.sv | 126 ++++++++++++
 tb/tb_instr_fetch_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_responder.sv
// Instruction-memory responder: word store with program-load port, one registered
// read stage and a 3-entry in-order output buffer with flush for branch redirects.
module instr_fetch_responder #(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             addr_valid,
    input  logic [31:0]      addr,
    output logic             addr_ready,
    input  logic             flush,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic             instr_fault,
    input  logic             instr_ready,
    input  logic             prog_we,
    input  logic [IDX_W-1:0] prog_idx,
    input  logic [31:0]      prog_data
);

    localparam int          DATA_W    = 32;
    localparam int          BUF_DEPTH = 3;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Misaligned or beyond the store: answered with a NOP marked as faulted.
    function automatic logic fetch_fault(input logic [31:0] a);
        logic [31:0] hi;
        hi = a >> (IDX_W + 2);
        return (a[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [DATA_W-1:0] store [DEPTH_WORDS];

    logic              vld_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic [31:0]       pc_p1;
    logic              fault_p1;

    logic [DATA_W-1:0] buf_instr [BUF_DEPTH];
    logic [31:0]       buf_pc    [BUF_DEPTH];
    logic              buf_fault [BUF_DEPTH];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [1:0]        count;

    logic [2:0]        occupancy;
    logic              accept;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_instr;

    // Occupancy counts the in-flight read so a stalled consumer can never overflow the buffer.
    assign occupancy   = {1'b0, count} + {2'b00, vld_p1};
    assign addr_ready  = !rst && !flush && (occupancy < 3'd3);
    assign accept      = addr_valid && addr_ready;
    assign instr_valid = !rst && (count != 2'd0);
    assign push        = vld_p1;
    assign pop         = instr_valid && instr_ready;
    assign push_instr  = fault_p1 ? NOP_INSTR : rdata_p1;

    assign instr       = instr_valid ? buf_instr[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : '0;
    assign instr_fault = instr_valid ? buf_fault[rd_ptr] : 1'b0;

    // Stage p0 -> p1: store access; a same-edge program write is seen on the next read.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            store[prog_idx] <= prog_data;
        end
        if (accept) begin
            rdata_p1 <= store[addr[IDX_W+1:2]];
            pc_p1    <= addr;
            fault_p1 <= fetch_fault(addr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    // Stage p1 -> buffer: entries written at the tail; a flushed push is simply never counted.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= push_instr;
            buf_pc[wr_ptr]    <= pc_p1;
            buf_fault[wr_ptr] <= fault_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: ordering, backpressure, faults, flush,
// program-load read-before-write and mid-stream reset.
module tb_instr_fetch_responder;

    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             addr_valid;
    logic [31:0]      addr;
    logic             addr_ready;
    logic             flush;
    logic             instr_valid;
    logic [31:0]      instr;
    logic [31:0]      instr_pc;
    logic             instr_fault;
    logic             instr_ready;
    logic             prog_we;
    logic [IDX_W-1:0] prog_idx;
    logic [31:0]      prog_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] words [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

    instr_fetch_responder #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .rst(rst), .addr_valid(addr_valid), .addr(addr), .addr_ready(addr_ready),
        .flush(flush), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_fault(instr_fault), .instr_ready(instr_ready), .prog_we(prog_we),
        .prog_idx(prog_idx), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; addr_valid = 1'b0; addr = '0; flush = 1'b0;
        instr_ready = 1'b0; prog_we = 1'b0; prog_idx = '0; prog_data = '0;
        for (int i = 0; i < 4; i++) begin
            prog_we = 1'b1; prog_idx = IDX_W'(i); prog_data = words[i];
            tick();
        end
        prog_we = 1'b0;
        tick();
        #1;
        checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL rst_addr_ready got %b want 0", addr_ready); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
        checks++; if (instr_fault !== 1'b0) begin errors++; $display("FAIL rst_instr_fault got %b want 0", instr_fault); end
        rst = 1'b0;
        #1;
        checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL post_rst_addr_ready got %b want 1", addr_ready); end
    endtask

    task automatic test_back_to_back();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            addr_valid = (i < 4);
            addr = 32'(4 * i);
            #1;
            if (i < 4) begin
                checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, addr_ready); end
            end
            tick();
            if (i == 0 || i == 5) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 0", i, instr_valid); end
            end else begin
                checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, instr_valid); end
                checks++; if (instr !== words[i-1]) begin errors++; $display("FAIL b2b_instr[%0d] got %h want %h", i, instr, words[i-1]); end
                checks++; if (instr_pc !== 32'(4 * (i - 1))) begin errors++; $display("FAIL b2b_pc[%0d] got %h want %h", i, instr_pc, 4 * (i - 1)); end
            end
        end
        addr_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int accepts;
        logic [31:0] next_addr;
        logic resumed;
        accepts = 0; next_addr = 32'h0; resumed = 1'b0;
        instr_ready = 1'b0;
        addr_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            addr = next_addr;
            #1;
            if (addr_ready) begin
                accepts++;
                next_addr = next_addr + 32'd4;
            end
            tick();
        end
        addr = next_addr;
        #1;
        checks++; if (accepts !== 3) begin errors++; $display("FAIL bp_accepts got %0d want 3", accepts); end
        checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b want 0", addr_ready); end
        checks++; if (addr !== 32'hC) begin errors++; $display("FAIL bp_next_addr got %h want 0000000c", addr); end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", k, instr_valid); end
            checks++; if (instr !== words[k]) begin errors++; $display("FAIL bp_instr[%0d] got %h want %h", k, instr, words[k]); end
            checks++; if (instr_pc !== 32'(4 * k)) begin errors++; $display("FAIL bp_pc[%0d] got %h want %h", k, instr_pc, 4 * k); end
            if (addr_valid && addr_ready) resumed = 1'b1;
            tick();
            if (resumed) addr_valid = 1'b0;
        end
        #1;
        checks++; if (resumed !== 1'b1) begin errors++; $display("FAIL bp_resume got %b want 1", resumed); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", instr_valid); end
        addr_valid = 1'b0;
    endtask

    task automatic test_fault();
        instr_ready = 1'b1;
        addr_valid = 1'b1; addr = 32'h6;
        tick();
        addr = 32'h400;
        tick();
        addr_valid = 1'b0;
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL flt6_instr got %h want 00000013", instr); end
        checks++; if (instr_fault !== 1'b1) begin errors++; $display("FAIL flt6_fault got %b want 1", instr_fault); end
        checks++; if (instr_pc !== 32'h6) begin errors++; $display("FAIL flt6_pc got %h want 00000006", instr_pc); end
        tick();
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL flt400_instr got %h want 00000013", instr); end
        checks++; if (instr_fault !== 1'b1) begin errors++; $display("FAIL flt400_fault got %b want 1", instr_fault); end
        checks++; if (instr_pc !== 32'h400) begin errors++; $display("FAIL flt400_pc got %h want 00000400", instr_pc); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flt_drained got %b want 0", instr_valid); end
    endtask

    task automatic test_flush();
        instr_ready = 1'b0;
        addr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 32'(4 * i);
            tick();
        end
        addr_valid = 1'b0;
        #1;
        checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL fl_full_ready got %b want 0", addr_ready); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fl_full_valid got %b want 1", instr_valid); end
        flush = 1'b1;
        #1;
        checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL fl_during_ready got %b want 0", addr_ready); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_after_valid got %b want 0", instr_valid); end
        checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL fl_after_ready got %b want 1", addr_ready); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_inflight_dropped got %b want 0", instr_valid); end
        instr_ready = 1'b1;
        addr_valid = 1'b1; addr = 32'h8;
        tick();
        addr_valid = 1'b0;
        tick();
        checks++; if (instr !== words[2]) begin errors++; $display("FAIL fl_refetch_instr got %h want %h", instr, words[2]); end
        checks++; if (instr_pc !== 32'h8) begin errors++; $display("FAIL fl_refetch_pc got %h want 00000008", instr_pc); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_single_entry got %b want 0", instr_valid); end
    endtask

    task automatic test_prog_write();
        instr_ready = 1'b1;
        addr_valid = 1'b1; addr = 32'h4;
        prog_we = 1'b1; prog_idx = 8'd1; prog_data = 32'hDEAD_BEEF;
        tick();
        addr_valid = 1'b0; prog_we = 1'b0;
        tick();
        checks++; if (instr !== words[1]) begin errors++; $display("FAIL pw_old_word got %h want %h", instr, words[1]); end
        tick();
        addr_valid = 1'b1; addr = 32'h4;
        tick();
        addr_valid = 1'b0;
        tick();
        checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pw_new_word got %h want deadbeef", instr); end
        checks++; if (instr_fault !== 1'b0) begin errors++; $display("FAIL pw_fault got %b want 0", instr_fault); end
        tick();
    endtask

    task automatic test_reset_midstream();
        instr_ready = 1'b0;
        addr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 32'(4 * i);
            tick();
        end
        addr_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL mr_during_ready got %b want 0", addr_ready); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", instr_valid); end
        checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL mr_ready got %b want 0", addr_ready); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL mr_instr got %h want 0", instr); end
        rst = 1'b0;
        #1;
        checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL mr_release_ready got %b want 1", addr_ready); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mr_release_valid got %b want 0", instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mr_no_stale got %b want 0", instr_valid); end
        instr_ready = 1'b1;
        addr_valid = 1'b1; addr = 32'h4;
        tick();
        addr = 32'h0;
        tick();
        addr_valid = 1'b0;
        checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mr_store1 got %h want deadbeef", instr); end
        tick();
        checks++; if (instr !== words[0]) begin errors++; $display("FAIL mr_store0 got %h want %h", instr, words[0]); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL mr_store0_pc got %h want 0", instr_pc); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_fault();
        test_flush();
        test_prog_write();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
